// File: rtl/flag_ctrl.sv
// flag_ctrl: architectural NZCV flag register with in-flight tracking.
//   Counts outstanding flag-setting ALU ops, applies masked flag updates
//   on writeback, accepts direct flag writes, and answers condition-code
//   checks through a single-entry valid/ready result slot. Checks and
//   direct writes stall until every outstanding update has landed.
// Ports:
//   clk, reset_n                  clock / async active-low reset
//   issue_valid/issue_ready       flag-setting op issue handshake
//   upd_valid, upd_flags, upd_mask  ALU writeback (bit3..0 = Z,N,C,V)
//   wr_valid, wr_flags, wr_ready  direct (MSR-style) flag write
//   chk_valid, chk_cond, chk_ready  condition-check request
//   res_valid, res_pass, res_ready  condition-check result slot
//   flags, pending, err           architectural state / sticky error
module flag_ctrl #(
  parameter int MAX_PEND = 3,
  parameter int PW       = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          upd_valid,
  input  logic [3:0]    upd_flags,
  input  logic [3:0]    upd_mask,
  input  logic          wr_valid,
  input  logic [3:0]    wr_flags,
  output logic          wr_ready,
  input  logic          chk_valid,
  input  logic [3:0]    chk_cond,
  output logic          chk_ready,
  output logic          res_valid,
  output logic          res_pass,
  input  logic          res_ready,
  output logic [3:0]    flags,
  output logic [PW-1:0] pending,
  output logic          err
);

  localparam logic [PW-1:0] PMAX    = PW'(MAX_PEND);
  localparam logic [0:0]    S_EMPTY = 1'b0;
  localparam logic [0:0]    S_FULL  = 1'b1;

  logic [0:0] state;
  logic       issue_fire, upd_apply, upd_spur, wr_fire, chk_fire;
  logic       cond_res;

  // Condition evaluation on the registered flags {Z,N,C,V}.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic z, n, c, v, r;
    z = f[3]; n = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c & !z;
      4'd9:    r = !c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z & (n == v);
      4'd13:   r = z | (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign res_valid   = (state == S_FULL);
  assign issue_ready = (pending != PMAX);
  assign wr_ready    = (pending == '0);
  // A result draining this cycle frees the slot for a new check.
  assign chk_ready   = (pending == '0) && (!res_valid || res_ready);

  assign issue_fire = issue_valid && issue_ready;
  assign upd_apply  = upd_valid && (pending != '0);
  assign upd_spur   = upd_valid && (pending == '0);
  assign wr_fire    = wr_valid && wr_ready;
  assign chk_fire   = chk_valid && chk_ready;
  assign cond_res   = cond_eval(chk_cond, flags);

  // Flags: direct write and update are mutually exclusive (pending gates both).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flags <= 4'b0000;
    else if (wr_fire)
      flags <= wr_flags;
    else if (upd_apply)
      flags <= (flags & ~upd_mask) | (upd_flags & upd_mask);
  end

  // Pending counter: issue and update in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pending <= '0;
    else if (issue_fire && !upd_apply)
      pending <= pending + 1'b1;
    else if (upd_apply && !issue_fire)
      pending <= pending - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err <= 1'b0;
    else if (upd_spur)
      err <= 1'b1;
  end

  // Result slot: res_pass only moves on a check fire so it holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_EMPTY;
      res_pass <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: if (chk_fire) begin
          state    <= S_FULL;
          res_pass <= cond_res;
        end
        default: if (chk_fire) begin
          state    <= S_FULL;
          res_pass <= cond_res;
        end else if (res_ready) begin
          state    <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: randomized + directed bench for flag_ctrl, checked against a
// cycle-level behavioural model of the flag register and result slot.
module tb_flag_ctrl;
  localparam int MAXP = 3;
  localparam int PW   = 3;

  logic          clk, reset_n;
  logic          issue_valid, issue_ready;
  logic          upd_valid;
  logic [3:0]    upd_flags, upd_mask;
  logic          wr_valid;
  logic [3:0]    wr_flags;
  logic          wr_ready;
  logic          chk_valid;
  logic [3:0]    chk_cond;
  logic          chk_ready;
  logic          res_valid, res_pass, res_ready;
  logic [3:0]    flags;
  logic [PW-1:0] pending;
  logic          err;

  flag_ctrl #(.MAX_PEND(MAXP), .PW(PW)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .upd_valid(upd_valid), .upd_flags(upd_flags), .upd_mask(upd_mask),
    .wr_valid(wr_valid), .wr_flags(wr_flags), .wr_ready(wr_ready),
    .chk_valid(chk_valid), .chk_cond(chk_cond), .chk_ready(chk_ready),
    .res_valid(res_valid), .res_pass(res_pass), .res_ready(res_ready),
    .flags(flags), .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  int      m_pend;
  bit      m_z, m_n, m_c, m_v;
  bit      m_rv, m_rp, m_er;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ARM encoding: pairs share a base predicate, odd codes invert it.
  function automatic bit m_cond(input int cc, input bit z, input bit n, input bit c, input bit v);
    bit b;
    case (cc >> 1)
      0: b = z;
      1: b = c;
      2: b = n;
      3: b = v;
      4: b = c && !z;
      5: b = (n == v);
      6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return (cc % 2 == 1) ? !b : b;
  endfunction

  function automatic logic [3:0] m_flags();
    return {m_z, m_n, m_c, m_v};
  endfunction

  task automatic m_reset();
    m_pend = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    m_rv = 0; m_rp = 0; m_er = 0;
  endtask

  // One cycle: drive at negedge, compare everything, advance model, cross posedge.
  task automatic step(input bit iv, input bit uv, input logic [3:0] uf, input logic [3:0] um,
                      input bit wv, input logic [3:0] wf, input bit cv, input logic [3:0] cc,
                      input bit rr);
    bit ifire, upd, spur, wfire, cfire, cres, ir, wr, cr;
    logic [3:0] f;
    @(negedge clk);
    issue_valid = iv; upd_valid = uv; upd_flags = uf; upd_mask = um;
    wr_valid = wv; wr_flags = wf; chk_valid = cv; chk_cond = cc; res_ready = rr;
    #1;
    ir = (m_pend < MAXP);
    wr = (m_pend == 0);
    cr = (m_pend == 0) && (!m_rv || rr);
    chk("flags", flags, m_flags());
    chk("pending", pending, m_pend);
    chk("res_valid", res_valid, m_rv);
    chk("res_pass", res_pass, m_rp);
    chk("err", err, m_er);
    chk("issue_ready", issue_ready, ir);
    chk("wr_ready", wr_ready, wr);
    chk("chk_ready", chk_ready, cr);
    ifire = iv && ir;
    upd   = uv && m_pend > 0;
    spur  = uv && m_pend == 0;
    wfire = wv && wr;
    cfire = cv && cr;
    cres  = m_cond(int'(cc), m_z, m_n, m_c, m_v);
    if (cfire) begin m_rv = 1; m_rp = cres; end
    else if (rr) m_rv = 0;
    f = m_flags();
    if (wfire) f = wf;
    else if (upd) for (int i = 0; i < 4; i++) if (um[i]) f[i] = uf[i];
    {m_z, m_n, m_c, m_v} = f;
    m_pend = m_pend + (ifire ? 1 : 0) - (upd ? 1 : 0);
    if (spur) m_er = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    issue_valid = 0; upd_valid = 0; wr_valid = 0; chk_valid = 0; res_ready = 0;
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("rst_flags", flags, 4'h0);
    chk("rst_pending", pending, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_pass", res_pass, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    issue_valid = 0; upd_valid = 0; upd_flags = 0; upd_mask = 0;
    wr_valid = 0; wr_flags = 0; chk_valid = 0; chk_cond = 0; res_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset with a held result and pending = 2
    step(1, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd14, 0);
    step(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    do_reset();
    idle(1);

    // 2: issue, update 1010/1111, EQ then GT
    step(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(0, 1, 4'b1010, 4'b1111, 0, 4'h0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd0, 1);
    step(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd12, 1);
    idle(2);

    // 3: saturate, then issue+update together
    repeat (4) step(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(1, 1, 4'b0110, 4'b1111, 0, 4'h0, 0, 4'h0, 1);
    step(1, 1, 4'b1001, 4'b0011, 0, 4'h0, 0, 4'h0, 1);
    repeat (3) step(0, 1, 4'b0001, 4'b0101, 0, 4'h0, 0, 4'h0, 1);
    idle(1);

    // 4: masked update ORs Z,N in; direct write waits for pending == 0
    step(0, 0, 4'h0, 4'h0, 1, 4'b0011, 0, 4'h0, 1);
    repeat (2) step(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(0, 1, 4'b1100, 4'b1100, 0, 4'h0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 4'h0, 1, 4'b0101, 0, 4'h0, 1);
    step(0, 1, 4'b0000, 4'b0000, 1, 4'b0101, 0, 4'h0, 1);
    step(1, 0, 4'h0, 4'h0, 1, 4'b0101, 0, 4'h0, 1);
    step(0, 1, 4'b0000, 4'b0000, 0, 4'h0, 0, 4'h0, 1);
    idle(1);

    // 5: backpressure on a passing result, then NV under res_ready
    step(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd14, 0);
    repeat (3) step(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd15, 0);
    step(0, 0, 4'h0, 4'h0, 0, 4'h0, 1, 4'd15, 1);
    idle(2);

    // Random traffic without spurious updates
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), (m_pend > 0) && ($urandom_range(0, 2) != 0),
           4'($urandom), 4'($urandom), $urandom_range(0, 1), 4'($urandom),
           $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 3) != 0);

    // 6: spurious update sets sticky err
    idle(1);
    while (m_pend > 0) step(0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    step(0, 1, 4'b1111, 4'b1111, 0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 4'($urandom),
           $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1), 4'($urandom),
           $urandom_range(0, 1) == 1);
    do_reset();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
